bit_repeat_packer: RTL and testbench

- Streaming producer of replicated-bit concatenation words, i.e. the `{N{x[i]}}, ...` patterns as a run stream.
- Accepts runs of (bit value, repeat count) over a valid/ready handshake.
- Expands each run into `count` copies of the bit and packs them LSB-first into OUT_WIDTH-bit words.
- Emits each word on a valid/ready output; sits directly upstream of the wide-concatenation consumers.

---
 rtl/bit_repeat_pkg.sv | 20 ++
 rtl/bit_repeat_out_slice.sv | 46 ++++
 rtl/bit_repeat_packer.sv | 134 +++++++++++++
 tb/tb_bit_repeat_packer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_repeat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_repeat_pkg
// Description : Shared constants and the run descriptor type for the
//               bit-repeat packer.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_repeat_pkg;

  localparam int OUT_WIDTH_DEFAULT   = 32;
  localparam int COUNT_WIDTH_DEFAULT = 5;

  // One run: a bit value and how many times it is replicated.
  typedef struct packed {
    logic                           value;
    logic [COUNT_WIDTH_DEFAULT-1:0] count;
  } run_t;

endpackage
`default_nettype wire

// File: rtl/bit_repeat_out_slice.sv
`default_nettype none
// ============================================================================
// Module      : bit_repeat_out_slice
// Description : Single-entry valid/ready output register holding a packed
//               word and its meaningful-bit count. Exposes o_free so the
//               producer knows a new word can be loaded this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_repeat_out_slice
  import bit_repeat_pkg::*;
#(
  parameter int DATA_W = OUT_WIDTH_DEFAULT,
  parameter int CNT_W  = $clog2(OUT_WIDTH_DEFAULT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_free,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count
);

  // The slot can take a word when empty or when its current word leaves now.
  assign o_free = !o_valid || i_ready;

  // Load a new word (possibly replacing one that is leaving), else drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_count <= i_count;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bit_repeat_packer.sv
`default_nettype none
// ============================================================================
// Module      : bit_repeat_packer
// Description : Accepts (bit, count) runs, expands each into count copies of
//               the bit and packs them LSB-first into OUT_WIDTH-bit words.
//               Long runs span several words; a flush request emits the
//               current partial word zero-padded with its bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_repeat_packer
  import bit_repeat_pkg::*;
#(
  parameter int OUT_WIDTH   = OUT_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int CNT_W       = $clog2(OUT_WIDTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_bit,
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [OUT_WIDTH-1:0]   o_data,
  output logic [CNT_W-1:0]       o_count
);

  // Common width for run/fill arithmetic, one bit of headroom for the sum.
  localparam int c_SW = ((COUNT_WIDTH > CNT_W) ? COUNT_WIDTH : CNT_W) + 1;

  logic                   r_run_bit;
  logic [COUNT_WIDTH-1:0] r_run_rem;
  logic [OUT_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]       r_fill;
  logic                   r_flush_pend;

  logic                   w_out_free;
  logic                   w_accept;
  logic                   w_run_active;
  logic [c_SW-1:0]        w_space;
  logic [c_SW-1:0]        w_rem_ext;
  logic [c_SW-1:0]        w_take;
  logic [c_SW-1:0]        w_new_fill;
  logic [OUT_WIDTH-1:0]   w_mask;
  logic [OUT_WIDTH-1:0]   w_acc_appended;
  logic                   w_word_full;
  logic                   w_flush_go;
  logic                   w_push;
  logic [OUT_WIDTH-1:0]   w_push_data;
  logic [CNT_W-1:0]       w_push_count;

  // New runs only when the previous one is fully placed and no flush waits;
  // held low throughout reset so nothing is accepted alongside it.
  assign i_ready      = !i_rst && (r_run_rem == '0) && !r_flush_pend;
  assign w_accept     = i_valid && i_ready;
  assign w_run_active = (r_run_rem != '0);

  // Work out how many bits of the current run fit and where they land.
  always_comb begin
    w_space    = c_SW'(OUT_WIDTH) - c_SW'(r_fill);
    w_rem_ext  = c_SW'(r_run_rem);
    w_take     = (w_rem_ext < w_space) ? w_rem_ext : w_space;
    w_new_fill = c_SW'(r_fill) + w_take;
    w_mask     = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      w_mask[i] = (i >= int'(r_fill)) && (i < int'(w_new_fill));
    end
    w_acc_appended = r_run_bit ? (r_acc | w_mask) : (r_acc & ~w_mask);
  end

  assign w_word_full = (w_new_fill == c_SW'(OUT_WIDTH));

  // A flush waits for the in-flight run to drain and for a free output slot.
  assign w_flush_go = r_flush_pend && !w_run_active && w_out_free;

  // Completed words and non-empty flushes both feed the output slice; they
  // never coincide because a flush only proceeds with no run in flight.
  assign w_push       = (w_run_active && w_word_full && w_out_free) ||
                        (w_flush_go && (r_fill != '0));
  assign w_push_data  = w_run_active ? w_acc_appended : r_acc;
  assign w_push_count = w_run_active ? CNT_W'(OUT_WIDTH) : r_fill;

  // Run capture, bit appending, word hand-off and flush bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run_bit    <= 1'b0;
      r_run_rem    <= '0;
      r_acc        <= '0;
      r_fill       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        // A zero count loads run_rem=0, so a null run simply vanishes.
        r_run_bit <= i_bit;
        r_run_rem <= i_count;
      end else if (w_run_active) begin
        if (!w_word_full) begin
          r_acc     <= w_acc_appended;
          r_fill    <= CNT_W'(w_new_fill);
          r_run_rem <= r_run_rem - COUNT_WIDTH'(w_take);
        end else if (w_out_free) begin
          r_acc     <= '0;
          r_fill    <= '0;
          r_run_rem <= r_run_rem - COUNT_WIDTH'(w_take);
        end
      end
      if (w_flush_go) begin
        r_acc  <= '0;
        r_fill <= '0;
      end
      r_flush_pend <= (r_flush_pend && !w_flush_go) || i_flush;
    end
  end

  bit_repeat_out_slice #(
    .DATA_W (OUT_WIDTH),
    .CNT_W  (CNT_W)
  ) u_out_slice (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_push),
    .i_data  (w_push_data),
    .i_count (w_push_count),
    .o_free  (w_out_free),
    .o_valid (o_valid),
    .i_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_bit_repeat_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_repeat_packer
// Description : Self-checking bench for bit_repeat_packer. A bit-queue model
//               produces the expected word stream; observed words are
//               collected by a monitor and compared per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_repeat_packer;
  import bit_repeat_pkg::*;

  localparam int OW = 32;
  localparam int CW = 5;
  localparam int NW = $clog2(OW + 1);

  typedef struct {
    logic [OW-1:0] data;
    logic [NW-1:0] count;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          i_bit = 1'b0;
  logic [CW-1:0] i_count = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [OW-1:0] o_data;
  logic [NW-1:0] o_count;

  int    tests = 0;
  int    fails = 0;
  bit    model_q[$];
  word_t exp_q[$];
  word_t got_q[$];

  always #5 clk = ~clk;

  bit_repeat_packer #(.OUT_WIDTH(OW), .COUNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_bit   (i_bit),
    .i_count (i_count),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  // Capture every word that completes an output handshake.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      word_t w;
      w.data  = o_data;
      w.count = o_count;
      got_q.push_back(w);
    end
  end

  // ---------------- reference model: a plain queue of bits ----------------
  task automatic model_emit(input int n);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i] = model_q.pop_front();
    w.count = NW'(n);
    exp_q.push_back(w);
  endtask

  task automatic model_run(input run_t r);
    for (int i = 0; i < int'(r.count); i++) model_q.push_back(r.value);
    while (model_q.size() >= OW) model_emit(OW);
  endtask

  task automatic model_flush();
    if (model_q.size() > 0) model_emit(model_q.size());
  endtask

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send_run(input logic b, input int c);
    run_t r;
    bit   ok;
    r.value = b;
    r.count = CW'(c);
    i_valid = 1'b1;
    i_bit   = b;
    i_count = CW'(c);
    ok      = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL run_accept_timeout: run (%0d,%0d) not accepted, i_ready=%0b required 1", b, c, i_ready);
    end else begin
      model_run(r);
    end
  endtask

  task automatic flush_pulse();
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    model_flush();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || i_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: o_valid=%0b i_ready=%0b required 0 0", o_valid, i_ready);
    end
    tests++;
    if (o_data !== '0 || o_count !== '0) begin
      fails++;
      $display("FAIL reset_outputs: o_data=%h o_count=%0d required 0 0", o_data, o_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (i_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: i_ready=%0b required 1", i_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_pack_basic();
    got_q.delete(); exp_q.delete();
    o_ready = 1'b1;
    send_run(1'b1, 1);
    send_run(1'b0, 8);
    send_run(1'b1, 16);
    send_run(1'b0, 7);
    // Accepted at the previous edge; the word must be visible after one more.
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_data !== 32'h01FFFE01) begin
      fails++;
      $display("FAIL basic_latency: o_valid=%0b o_data=%h required 1 01fffe01", o_valid, o_data);
    end
    idle(4);
    tests++;
    if (got_q.size() !== 1 || got_q[0].data !== 32'h01FFFE01 || got_q[0].count !== NW'(32)) begin
      fails++;
      $display("FAIL basic_word: words=%0d data=%h count=%0d required 1 01fffe01 32",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0, (got_q.size() > 0) ? got_q[0].count : '0);
    end
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL basic_model_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_split();
    got_q.delete(); exp_q.delete();
    send_run(1'b1, 20);
    send_run(1'b0, 20);
    send_run(1'b1, 24);
    idle(4);
    flush_pulse();
    idle(6);
    tests++;
    if (got_q.size() !== 2) begin
      fails++;
      $display("FAIL split_count: got %0d words required 2 (flush of empty acc must emit nothing)", got_q.size());
    end else begin
      tests++;
      if (got_q[0].data !== 32'h000FFFFF || got_q[1].data !== 32'hFFFFFF00) begin
        fails++;
        $display("FAIL split_data: got %h %h required 000fffff ffffff00", got_q[0].data, got_q[1].data);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].count !== exp_q[i].count) begin
        fails++;
        $display("FAIL split_model[%0d]: got %h/%0d required %h/%0d", i, got_q[i].data, got_q[i].count, exp_q[i].data, exp_q[i].count);
      end
    end
  endtask

  task automatic test_flush();
    got_q.delete(); exp_q.delete();
    send_run(1'b1, 5);
    flush_pulse();
    idle(6);
    tests++;
    if (got_q.size() !== 1 || got_q[0].data !== 32'h0000001F || got_q[0].count !== NW'(5)) begin
      fails++;
      $display("FAIL flush_partial: words=%0d data=%h count=%0d required 1 0000001f 5",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0, (got_q.size() > 0) ? got_q[0].count : '0);
    end
    flush_pulse();
    idle(6);
    tests++;
    if (got_q.size() !== 1) begin
      fails++;
      $display("FAIL flush_empty: got %0d words required 1", got_q.size());
    end
    tests++;
    if (i_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_ready_after: i_ready=%0b required 1", i_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    bit            seen;
    got_q.delete(); exp_q.delete();
    o_ready = 1'b0;
    seen    = 1'b0;
    held    = '0;
    fork
      begin
        for (int n = 0; n < 6; n++) send_run(1'b1, 16);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (o_valid) begin
            if (!seen) begin
              seen = 1'b1;
              held = o_data;
            end
            tests++;
            if (o_data !== 32'hFFFFFFFF || o_data !== held || o_count !== NW'(32)) begin
              fails++;
              $display("FAIL bp_hold: o_data=%h o_count=%0d required ffffffff 32 stable", o_data, o_count);
            end
          end
        end
        tests++;
        if (o_valid !== 1'b1 || i_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_stall: o_valid=%0b i_ready=%0b required 1 0", o_valid, i_ready);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    idle(8);
    tests++;
    if (got_q.size() !== 3) begin
      fails++;
      $display("FAIL bp_words: got %0d words required 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].data !== 32'hFFFFFFFF || got_q[i].data !== exp_q[i].data || got_q[i].count !== exp_q[i].count) begin
        fails++;
        $display("FAIL bp_model[%0d]: got %h/%0d required %h/%0d", i, got_q[i].data, got_q[i].count, exp_q[i].data, exp_q[i].count);
      end
    end
  endtask

  task automatic test_null_run();
    got_q.delete(); exp_q.delete();
    send_run(1'b1, 0);
    send_run(1'b0, 31);
    send_run(1'b1, 0);
    send_run(1'b1, 1);
    idle(5);
    tests++;
    if (got_q.size() !== 1 || got_q[0].data !== 32'h80000000 || got_q[0].count !== NW'(32)) begin
      fails++;
      $display("FAIL null_run: words=%0d data=%h required 1 80000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0);
    end
  endtask

  task automatic test_random();
    bit rnd_done;
    got_q.delete(); exp_q.delete();
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          send_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
          if ($urandom_range(0, 7) == 0) flush_pulse();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          o_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    o_ready = 1'b1;
    flush_pulse();
    idle(20);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].count !== exp_q[i].count) begin
        fails++;
        $display("FAIL random_word[%0d]: got %h/%0d required %h/%0d", i, got_q[i].data, got_q[i].count, exp_q[i].data, exp_q[i].count);
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); exp_q.delete();
    o_ready = 1'b1;
    send_run(1'b1, 12);
    idle(2);
    rst = 1'b1;
    model_q.delete();
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || i_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_during: o_valid=%0b i_ready=%0b required 0 0", o_valid, i_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after: i_ready=%0b o_valid=%0b required 1 0", i_ready, o_valid);
    end
    @(posedge clk);
    #1;
    send_run(1'b0, 31);
    send_run(1'b0, 1);
    idle(4);
    flush_pulse();
    idle(6);
    tests++;
    if (got_q.size() !== 1 || got_q[0].data !== 32'h00000000 || got_q[0].count !== NW'(32)) begin
      fails++;
      $display("FAIL rstmid_word: words=%0d data=%h count=%0d required 1 00000000 32",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0, (got_q.size() > 0) ? got_q[0].count : '0);
    end
  endtask

  initial begin
    test_reset();
    test_pack_basic();
    test_split();
    test_flush();
    test_backpressure();
    test_null_run();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
